// File: rtl/voice_mix_scheduler.sv
// Shares one sine-table ROM port among three tone voices per frame pulse,
// advancing each voice's phase and emitting one saturated 16-bit mixed sample.
module voice_mix_scheduler #(
   parameter int unsigned PHASE_BITS = 22,
   parameter int unsigned ADDR_BITS  = 10,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sampling_pulse,
   input  logic [2:0]            voice_active,
   input  logic [PHASE_BITS-1:0] step0,
   input  logic [PHASE_BITS-1:0] step1,
   input  logic [PHASE_BITS-1:0] step2,
   output logic                  rom_req,
   output logic [ADDR_BITS-1:0]  rom_addr,
   input  logic [15:0]           rom_data,
   input  logic                  rom_valid,
   output logic [15:0]           sample,
   output logic                  sample_ready,
   output logic                  busy,
   output logic                  overrun,
   output logic                  rom_error
);

   localparam int unsigned NUM_VOICES = 3;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned SAMPLE_W   = 16;
   localparam int unsigned SUM_W      = 18;
   localparam int unsigned TMO_W      = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_REQ,
      S_WAIT,
      S_OUTPUT
   } state_t;

   state_t                       state, state_nxt;
   logic [NUM_VOICES-1:0]        mask, mask_nxt;
   logic [IDX_W-1:0]             idx, idx_nxt;
   logic [TMO_W-1:0]             tmo_cnt, tmo_nxt;
   logic signed [SUM_W-1:0]      sum, sum_nxt;
   logic [PHASE_BITS-1:0]        phase     [NUM_VOICES];
   logic [PHASE_BITS-1:0]        phase_nxt [NUM_VOICES];

   logic                         rom_req_nxt;
   logic [ADDR_BITS-1:0]         rom_addr_nxt;
   logic [SAMPLE_W-1:0]          sample_nxt;
   logic                         sample_ready_nxt;
   logic                         busy_nxt;
   logic                         overrun_nxt;
   logic                         rom_error_nxt;

   logic                         sel_found;
   logic [IDX_W-1:0]             sel_idx;
   logic [PHASE_BITS-1:0]        cur_step;
   logic signed [SUM_W-1:0]      sum_half;
   logic [SAMPLE_W-1:0]          sample_sat;
   logic                         wait_done;

   // Lowest enabled voice at or above the current index
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
         if (mask[i] && (IDX_W'(i) >= idx)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      case (idx)
         2'd0:    cur_step = step0;
         2'd1:    cur_step = step1;
         default: cur_step = step2;
      endcase
   end

   // Halve the frame sum and clamp to the 16-bit sample range
   always_comb begin
      sum_half = sum >>> 1;
      if ((&sum_half[SUM_W-1:SAMPLE_W-1]) || !(|sum_half[SUM_W-1:SAMPLE_W-1]))
         sample_sat = sum_half[SAMPLE_W-1:0];
      else if (sum_half[SUM_W-1])
         sample_sat = 16'h8000;
      else
         sample_sat = 16'h7FFF;
   end

   assign wait_done = rom_valid || (tmo_cnt == TMO_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt        = state;
      mask_nxt         = mask;
      idx_nxt          = idx;
      tmo_nxt          = tmo_cnt;
      sum_nxt          = sum;
      phase_nxt        = phase;
      rom_req_nxt      = 1'b0;
      rom_addr_nxt     = rom_addr;
      sample_nxt       = sample;
      sample_ready_nxt = 1'b0;
      busy_nxt         = busy;
      overrun_nxt      = overrun;
      rom_error_nxt    = rom_error;

      if (sampling_pulse && (state != S_IDLE))
         overrun_nxt = 1'b1;

      case (state)
         S_IDLE: begin
            if (sampling_pulse) begin
               mask_nxt  = voice_active;
               sum_nxt   = '0;
               idx_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = S_SELECT;
               // Disabled voices restart from phase 0 when re-enabled
               for (int i = 0; i < int'(NUM_VOICES); i++) begin
                  if (!voice_active[i])
                     phase_nxt[i] = '0;
               end
            end
         end

         S_SELECT: begin
            if (sel_found) begin
               idx_nxt      = sel_idx;
               rom_req_nxt  = 1'b1;
               rom_addr_nxt = phase[sel_idx][PHASE_BITS-1 -: ADDR_BITS];
               tmo_nxt      = '0;
               state_nxt    = S_REQ;
            end else begin
               state_nxt = S_OUTPUT;
            end
         end

         S_REQ: begin
            state_nxt = S_WAIT;
         end

         S_WAIT: begin
            if (wait_done) begin
               // A timed-out read contributes nothing but still advances the phase
               if (rom_valid)
                  sum_nxt = sum + SUM_W'($signed(rom_data));
               else
                  rom_error_nxt = 1'b1;
               phase_nxt[idx] = phase[idx] + cur_step;
               idx_nxt        = idx + IDX_W'(1);
               state_nxt      = S_SELECT;
            end else begin
               tmo_nxt = tmo_cnt + TMO_W'(1);
            end
         end

         S_OUTPUT: begin
            sample_nxt       = sample_sat;
            sample_ready_nxt = 1'b1;
            busy_nxt         = 1'b0;
            state_nxt        = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         mask         <= '0;
         idx          <= '0;
         tmo_cnt      <= '0;
         sum          <= '0;
         for (int i = 0; i < int'(NUM_VOICES); i++)
            phase[i] <= '0;
         rom_req      <= 1'b0;
         rom_addr     <= '0;
         sample       <= '0;
         sample_ready <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         rom_error    <= 1'b0;
      end else begin
         state        <= state_nxt;
         mask         <= mask_nxt;
         idx          <= idx_nxt;
         tmo_cnt      <= tmo_nxt;
         sum          <= sum_nxt;
         phase        <= phase_nxt;
         rom_req      <= rom_req_nxt;
         rom_addr     <= rom_addr_nxt;
         sample       <= sample_nxt;
         sample_ready <= sample_ready_nxt;
         busy         <= busy_nxt;
         overrun      <= overrun_nxt;
         rom_error    <= rom_error_nxt;
      end
   end

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Randomized bench for voice_mix_scheduler against a frame-level reference of
// phases, mixed sums, latency and sticky flags.
module tb_voice_mix_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        sampling_pulse;
   logic [2:0]  voice_active;
   logic [21:0] step0, step1, step2;
   logic        rom_req;
   logic [9:0]  rom_addr;
   logic [15:0] rom_data;
   logic        rom_valid;
   logic [15:0] sample;
   logic        sample_ready;
   logic        busy;
   logic        overrun;
   logic        rom_error;

   voice_mix_scheduler dut (
      .clk            (clk),
      .reset          (reset),
      .sampling_pulse (sampling_pulse),
      .voice_active   (voice_active),
      .step0          (step0),
      .step1          (step1),
      .step2          (step2),
      .rom_req        (rom_req),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .rom_valid      (rom_valid),
      .sample         (sample),
      .sample_ready   (sample_ready),
      .busy           (busy),
      .overrun        (overrun),
      .rom_error      (rom_error)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state
   logic [21:0] st        [3];
   logic [21:0] ref_phase [3];
   logic [15:0] ref_sample;
   logic        ref_overrun;
   logic        ref_error;
   logic [15:0] rom_mem   [1024];

   // Main -> ROM model control
   int          frame_seq = 0;
   int          spur_seq  = 0;
   int          rom_drop  = -1;
   int          exp_n     = 0;
   logic [9:0]  exp_addr  [3];
   // ROM model -> main
   int          rom_seq   = 0;
   int          spur_done = 0;
   int          req_cnt   = 0;

   assign step0 = st[0];
   assign step1 = st[1];
   assign step2 = st[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Shared ROM: answers each request one cycle later unless told to drop it
   initial begin : rom_model
      logic        pend;
      logic [15:0] pend_data;
      pend      = 1'b0;
      pend_data = '0;
      rom_valid = 1'b0;
      rom_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rom_seq != frame_seq) begin
            rom_seq = frame_seq;
            req_cnt = 0;
         end
         rom_valid = 1'b0;
         if (reset) begin
            pend = 1'b0;
         end else if (pend) begin
            rom_valid = 1'b1;
            rom_data  = pend_data;
            pend      = 1'b0;
         end else if (spur_done != spur_seq) begin
            spur_done = spur_seq;
            rom_valid = 1'b1;
            rom_data  = 16'($urandom);
         end
         if (rom_req && !reset) begin
            if (req_cnt < exp_n)
               check_eq("rom_addr", 32'(rom_addr), 32'(exp_addr[req_cnt]));
            else
               check_eq("rom_req_count", 32'(req_cnt + 1), 32'(exp_n));
            if (req_cnt != rom_drop) begin
               pend      = 1'b1;
               pend_data = rom_mem[rom_addr];
            end
            req_cnt++;
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_rom_req"},      32'(rom_req),      32'(0));
      check_eq({tag, "_rom_addr"},     32'(rom_addr),     32'(0));
      check_eq({tag, "_sample"},       32'(sample),       32'(0));
      check_eq({tag, "_sample_ready"}, 32'(sample_ready), 32'(0));
      check_eq({tag, "_busy"},         32'(busy),         32'(0));
      check_eq({tag, "_overrun"},      32'(overrun),      32'(0));
      check_eq({tag, "_rom_error"},    32'(rom_error),    32'(0));
   endtask

   // One frame: predict, pulse, wait for the sample and compare everything
   task automatic run_frame(input logic [2:0] m, input int drop, input bit inject);
      int n, sum, o, lat, k, extra, d;
      logic [9:0] a;
      n   = 0;
      sum = 0;
      lat = 2;
      for (int v = 0; v < 3; v++) begin
         if (m[v]) begin
            a           = ref_phase[v][21:12];
            exp_addr[n] = a;
            if (n == drop) begin
               ref_error = 1'b1;
               lat       = lat + 14;
            end else begin
               d   = $signed(rom_mem[a]);
               sum = sum + d;
            end
            ref_phase[v] = ref_phase[v] + st[v];
            lat          = lat + 3;
            n++;
         end else begin
            ref_phase[v] = '0;
         end
      end
      o = sum >>> 1;
      if (o > 32767)  o = 32767;
      if (o < -32768) o = -32768;
      ref_sample = 16'(o);
      exp_n      = n;
      rom_drop   = drop;
      frame_seq++;

      @(negedge clk);
      voice_active   = m;
      sampling_pulse = 1'b1;
      @(posedge clk);
      #1;
      sampling_pulse = 1'b0;
      voice_active   = 3'($urandom);
      check_eq("busy_start", 32'(busy), 32'(1));
      k = 0;
      while (!sample_ready && k < 300) begin
         @(posedge clk);
         #1;
         k++;
         if (inject && k == 2 && lat >= 3) begin
            sampling_pulse = 1'b1;
            ref_overrun    = 1'b1;
         end else begin
            sampling_pulse = 1'b0;
         end
      end
      sampling_pulse = 1'b0;
      check_eq("latency",   32'(k),         32'(lat));
      check_eq("sample",    32'(sample),    32'(ref_sample));
      check_eq("busy_end",  32'(busy),      32'(0));
      check_eq("rom_error", 32'(rom_error), 32'(ref_error));
      check_eq("overrun",   32'(overrun),   32'(ref_overrun));
      check_eq("req_pulses", 32'(req_cnt),  32'(n));
      extra = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (sample_ready) extra++;
      end
      check_eq("extra_ready", 32'(extra),  32'(0));
      check_eq("sample_hold", 32'(sample), 32'(ref_sample));
   endtask

   initial begin
      int cnt;
      reset          = 1'b1;
      sampling_pulse = 1'b0;
      voice_active   = '0;
      for (int v = 0; v < 3; v++) begin
         st[v]        = '0;
         ref_phase[v] = '0;
      end
      for (int a = 0; a < 1024; a++) rom_mem[a] = '0;
      ref_sample  = '0;
      ref_overrun = 1'b0;
      ref_error   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Single voice, ROM returns its address
      for (int a = 0; a < 1024; a++) rom_mem[a] = 16'(a);
      st[0] = 22'h001000;
      st[1] = 22'($urandom);
      st[2] = 22'($urandom);
      repeat (3) run_frame(3'b001, -1, 1'b0);

      // Saturation both ways, then an empty frame
      for (int a = 0; a < 1024; a++) rom_mem[a] = 16'h7FFF;
      run_frame(3'b111, -1, 1'b0);
      for (int a = 0; a < 1024; a++) rom_mem[a] = 16'h8000;
      run_frame(3'b111, -1, 1'b0);
      run_frame(3'b000, -1, 1'b0);

      // Overrun is sticky across later frames
      for (int a = 0; a < 1024; a++) rom_mem[a] = 16'($urandom);
      run_frame(3'b111, -1, 1'b1);
      run_frame(3'b010, -1, 1'b0);

      // Voice 1 never answered
      st[1] = 22'($urandom);
      run_frame(3'b111, 1, 1'b0);
      run_frame(3'b111, -1, 1'b0);

      // Reset while stuck waiting on the ROM
      for (int v = 0; v < 3; v++) exp_addr[v] = ref_phase[v][21:12];
      exp_n    = 3;
      rom_drop = 0;
      frame_seq++;
      @(negedge clk);
      voice_active   = 3'b111;
      sampling_pulse = 1'b1;
      @(posedge clk);
      #1;
      sampling_pulse = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_idle_outputs("reset_mid");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int v = 0; v < 3; v++) ref_phase[v] = '0;
      ref_sample  = '0;
      ref_overrun = 1'b0;
      ref_error   = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (sample_ready) cnt++;
      end
      check_eq("stale_ready", 32'(cnt), 32'(0));
      run_frame(3'b111, -1, 1'b0);

      // Random frames
      for (int f = 0; f < 40; f++) begin
         int drop;
         for (int v = 0; v < 3; v++)
            if ($urandom_range(0, 2) == 0) st[v] = 22'($urandom);
         drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
         if ($urandom_range(0, 3) == 0) begin
            spur_seq++;
            repeat (2) @(posedge clk);
         end
         run_frame(3'($urandom), drop, ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
